// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// hazard stall, synchronous flush with bubble insertion, optional 2-entry
// skid buffer and a saturating count of instructions squashed by flush.
module pipe_stage_reg #(
  parameter int CTRL_W         = 16,
  parameter int DATA_W         = 192,
  parameter int SKID           = 1,
  parameter int FLUSH_DATA_CLR = 0,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  squash_cnt
);

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic              r_main_vld;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CNT_W-1:0]  r_squash_cnt;

  logic              w_r;          // effective downstream ready
  logic              w_in_xfer;
  logic              w_skid_vld;   // 0 when there is no skid entry
  logic              w_main_sq;    // main is discarded (not delivered) by flush
  logic [1:0]        w_sq;
  logic [CNT_W+1:0]  w_cnt_sum;

  assign w_r       = out_ready & ~stall;
  assign w_in_xfer = in_valid & in_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_skid_vld;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;

      // Registered ready: the skid slot absorbs the one input that may land
      // while the stage decides it is blocked, so out_ready never reaches in_ready.
      assign in_ready   = ~r_skid_vld;
      assign w_skid_vld = r_skid_vld;

      // Main/skid update; skid always holds the older entry and drains first.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_main_vld  <= 1'b0;
          r_main_ctrl <= '0;
          r_main_data <= '0;
          r_skid_vld  <= 1'b0;
          r_skid_ctrl <= '0;
          r_skid_data <= '0;
        end else if (flush) begin
          r_main_vld  <= 1'b0;
          r_main_ctrl <= '0;
          r_skid_vld  <= 1'b0;
          r_skid_ctrl <= '0;
          if (FLUSH_DATA_CLR != 0) begin
            r_main_data <= '0;
            r_skid_data <= '0;
          end
        end else if (!r_main_vld || w_r) begin
          if (r_skid_vld) begin
            r_main_vld  <= 1'b1;
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
            if (w_in_xfer) begin
              r_skid_ctrl <= in_ctrl;
              r_skid_data <= in_data;
            end else begin
              r_skid_vld  <= 1'b0;
            end
          end else begin
            r_main_vld <= w_in_xfer;
            if (w_in_xfer) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
            end
          end
        end else if (w_in_xfer) begin
          r_skid_vld  <= 1'b1;
          r_skid_ctrl <= in_ctrl;
          r_skid_data <= in_data;
        end
      end
    end else begin : g_noskid
      // Combinational ready: accept when empty or when draining this cycle.
      assign in_ready   = ~r_main_vld | w_r;
      assign w_skid_vld = 1'b0;

      // Single register: load on input transfer, empty on output-only transfer.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_main_vld  <= 1'b0;
          r_main_ctrl <= '0;
          r_main_data <= '0;
        end else if (flush) begin
          r_main_vld  <= 1'b0;
          r_main_ctrl <= '0;
          if (FLUSH_DATA_CLR != 0) r_main_data <= '0;
        end else if (w_in_xfer) begin
          r_main_vld  <= 1'b1;
          r_main_ctrl <= in_ctrl;
          r_main_data <= in_data;
        end else if (r_main_vld && w_r) begin
          r_main_vld  <= 1'b0;
        end
      end
    end
  endgenerate

  // An entry leaving downstream in the flush cycle was delivered, not squashed.
  assign w_main_sq = r_main_vld & ~w_r;
  assign w_sq      = {1'b0, w_main_sq} + {1'b0, w_skid_vld} + {1'b0, w_in_xfer};
  assign w_cnt_sum = {2'b00, r_squash_cnt} + {{CNT_W{1'b0}}, w_sq};

  // Saturating squash counter, stepped only by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_squash_cnt <= '0;
    else if (flush) r_squash_cnt <= (w_cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
  end

  assign out_valid  = r_main_vld;
  assign out_ctrl   = r_main_vld ? r_main_ctrl : '0;
  assign out_data   = r_main_data;
  assign squash_cnt = r_squash_cnt;

endmodule
